fp_pack_round: RTL and testbench

Output-side companion to the operand unpack/denormal-detect stage of the single-precision FPU. Takes an unnormalized result (sign, wide signed biased exponent, significand with guard/round/sticky bits, special-case flags). Normalizes it iteratively, denormalizes on underflow, rounds, and packs an IEEE-754 binary32 word with exception flags. It sits at the tail of the add/sub/mul datapath and uses a valid/ready handshake on both sides.

---
 rtl/fp_pack_round.sv | 164 ++++++++++++++++
 tb/tb_fp_pack_round.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_pack_round.sv
// fp_pack_round: normalize, denormalize, round and pack a binary32 result.
// Takes the unnormalized sign/exponent/significand bundle from the FPU
// datapath, aligns it one bit per cycle, rounds once and holds the packed
// word with its exception flags until the consumer takes it.
// Build option: define FPU_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise the unit rounds toward zero.
module fp_pack_round (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [27:0] in_sig,
    input  logic        in_nan,
    input  logic        in_inf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_invalid,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

`ifdef FPU_ROUND_NEAREST_EN
    localparam bit RNE_EN = 1'b1;
`else
    localparam bit RNE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    // One bit wider than the input so carry/round increments at the top
    // of the input range cannot wrap.
    logic signed [10:0] exp_q, exp_d;
    logic [27:0]        sig_q, sig_d;
    logic [31:0]        result_q, result_d;
    // {invalid, overflow, underflow, inexact}
    logic [3:0]         flags_q, flags_d;

    logic [24:0]        sig_rnd;
    logic signed [10:0] exp_rnd;
    logic               inexact_w;
    logic               ovf_w;

    // Increment decision on the rounding bits; always zero when truncating.
    function automatic logic round_up(input logic lsb, input logic g,
                                      input logic r, input logic s);
        return RNE_EN & g & (r | s | lsb);
    endfunction

    // Overflow saturates to infinity for RNE, to max finite for RTZ.
    function automatic logic [31:0] sat_result(input logic sign);
        return RNE_EN ? {sign, 8'hFF, 23'h000000} : {sign, 8'hFE, 23'h7FFFFF};
    endfunction

    // Round the aligned significand; a carry out renormalizes to 1.0 x 2^(e+1).
    always_comb begin
        inexact_w = |sig_q[2:0];
        sig_rnd   = sig_q[27:3] + {24'b0, round_up(sig_q[3], sig_q[2], sig_q[1], sig_q[0])};
        exp_rnd   = exp_q;
        if (sig_rnd[24]) begin
            sig_rnd = 25'h0800000;
            exp_rnd = exp_q + 11'sd1;
        end
        ovf_w = (exp_rnd >= 11'sd255);
    end

    // Next-state and datapath update for the capture/align/round/done sequence.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {in_exp[9], in_exp};
                    sig_d   = in_sig;
                    flags_d = 4'b0000;
                    if (in_nan) begin
                        result_d = 32'h7FC00000;
                        flags_d  = 4'b1000;
                        state_d  = DONE;
                    end else if (in_inf) begin
                        result_d = {in_sign, 8'hFF, 23'h000000};
                        state_d  = DONE;
                    end else if (in_sig == 28'h0) begin
                        result_d = {in_sign, 31'b0};
                        state_d  = DONE;
                    end else if ($signed(in_exp) < -10'sd26) begin
                        // Too small to survive any shift: collapse to sticky only.
                        sig_d   = {27'b0, |in_sig};
                        exp_d   = 11'sd1;
                        state_d = ALIGN;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (sig_q[27] || (exp_q < 11'sd1)) begin
                    sig_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
                    exp_d = exp_q + 11'sd1;
                end else if (!sig_q[26] && (exp_q > 11'sd1)) begin
                    sig_d = {sig_q[26:0], 1'b0};
                    exp_d = exp_q - 11'sd1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (ovf_w) begin
                    result_d = sat_result(sign_q);
                end else begin
                    result_d = {sign_q, sig_rnd[23] ? exp_rnd[7:0] : 8'h00, sig_rnd[22:0]};
                end
                flags_d = {1'b0, ovf_w, ~sig_rnd[23] & inexact_w, inexact_w | ovf_w};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible outputs: cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= 32'h0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Working significand/exponent: only meaningful while an operation is in flight.
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
        sig_q  <= sig_d;
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign result         = result_q;
    assign flag_invalid   = flags_q[3];
    assign flag_overflow  = flags_q[2];
    assign flag_underflow = flags_q[1];
    assign flag_inexact   = flags_q[0];

endmodule

// File: tb/tb_fp_pack_round.sv
// Testbench for fp_pack_round: scoreboard of expected results, per-feature tasks.
module tb_fp_pack_round;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_sig;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        logic [3:0]  mask;
        int          lat;
    } exp_t;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [27:0] sg;
        logic        nan;
        logic        inf;
        logic [31:0] xr;
        logic [3:0]  xf;
        logic [3:0]  xm;
        int          xl;
    } vec_t;

    exp_t sb_q[$];

`ifdef FPU_ROUND_NEAREST_EN
    localparam logic [31:0] R_RND1   = 32'h3F800002;
    localparam logic [31:0] R_OVF    = 32'h7F800000;
    localparam logic [31:0] R_DEN    = 32'h00800000;
    localparam logic [3:0]  F_DEN    = 4'b0001;
    localparam logic [3:0]  F_OVF254 = 4'b0101;
    localparam logic [3:0]  M_OVF254 = 4'b1111;
`else
    localparam logic [31:0] R_RND1   = 32'h3F800001;
    localparam logic [31:0] R_OVF    = 32'h7F7FFFFF;
    localparam logic [31:0] R_DEN    = 32'h007FFFFF;
    localparam logic [3:0]  F_DEN    = 4'b0011;
    localparam logic [3:0]  F_OVF254 = 4'b0001;
    localparam logic [3:0]  M_OVF254 = 4'b1011;
`endif

    fp_pack_round dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_sig         (in_sig),
        .in_nan         (in_nan),
        .in_inf         (in_inf),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_invalid   (flag_invalid),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_inexact   (flag_inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic drive_op(input vec_t v);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
        end
        in_sign  = v.s;
        in_exp   = v.e;
        in_sig   = v.sg;
        in_nan   = v.nan;
        in_inf   = v.inf;
        in_valid = 1'b1;
        sb_q.push_back('{v.xr, v.xf, v.xm, v.xl});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Latency counts accept edge as 0; out_valid seen after edge N-1 means cycle N.
    task automatic wait_out(output logic [31:0] r, output logic [3:0] f,
                            output int lat, output exp_t x);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        r = result;
        f = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};
        x = sb_q.pop_front();
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 10'h0;
        in_sig    = 28'h0;
        in_nan    = 1'b0;
        in_inf    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        cmp_cnt++; if (result !== 32'h0) begin err_cnt++; $display("FAIL reset_result: got %h want 00000000", result); end
        cmp_cnt++;
        if ({flag_invalid, flag_overflow, flag_underflow, flag_inexact} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b want 0000",
                     {flag_invalid, flag_overflow, flag_underflow, flag_inexact});
        end
    endtask

    task automatic test_normalize();
        vec_t v[4];
        logic [31:0] r; logic [3:0] f; int l; exp_t x;
        v[0] = '{1'b0, 10'd127, 28'h4000000, 1'b0, 1'b0, 32'h3F800000, 4'b0000, 4'hF, 3};
        v[1] = '{1'b0, 10'd130, 28'h0800000, 1'b0, 1'b0, 32'h3F800000, 4'b0000, 4'hF, 6};
        v[2] = '{1'b0, 10'd127, 28'h8000000, 1'b0, 1'b0, 32'h40000000, 4'b0000, 4'hF, 4};
        v[3] = '{1'b1, 10'd128, 28'h4000000, 1'b0, 1'b0, 32'hC0000000, 4'b0000, 4'hF, 3};
        foreach (v[i]) begin
            drive_op(v[i]);
            wait_out(r, f, l, x);
            cmp_cnt++; if (r !== x.res) begin err_cnt++; $display("FAIL normalize[%0d] result: got %h want %h", i, r, x.res); end
            cmp_cnt++; if ((f & x.mask) !== (x.flags & x.mask)) begin err_cnt++; $display("FAIL normalize[%0d] flags: got %b want %b", i, f, x.flags); end
            cmp_cnt++; if (l !== x.lat) begin err_cnt++; $display("FAIL normalize[%0d] latency: got %0d want %0d", i, l, x.lat); end
            handshake();
        end
    endtask

    task automatic test_rounding();
        vec_t v[3];
        logic [31:0] r; logic [3:0] f; int l; exp_t x;
        v[0] = '{1'b0, 10'd127, 28'h400000C, 1'b0, 1'b0, R_RND1,       4'b0001, 4'hF, 3};
        v[1] = '{1'b0, 10'd127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 4'b0001, 4'hF, 3};
        v[2] = '{1'b0, 10'd1,   28'h3FFFFFC, 1'b0, 1'b0, R_DEN,        F_DEN,   4'hF, 3};
        foreach (v[i]) begin
            drive_op(v[i]);
            wait_out(r, f, l, x);
            cmp_cnt++; if (r !== x.res) begin err_cnt++; $display("FAIL rounding[%0d] result: got %h want %h", i, r, x.res); end
            cmp_cnt++; if ((f & x.mask) !== (x.flags & x.mask)) begin err_cnt++; $display("FAIL rounding[%0d] flags: got %b want %b", i, f, x.flags); end
            cmp_cnt++; if (l !== x.lat) begin err_cnt++; $display("FAIL rounding[%0d] latency: got %0d want %0d", i, l, x.lat); end
            handshake();
        end
    endtask

    task automatic test_overflow();
        vec_t v[2];
        logic [31:0] r; logic [3:0] f; int l; exp_t x;
        v[0] = '{1'b0, 10'd255, 28'h4000000, 1'b0, 1'b0, R_OVF, 4'b0101,  4'hF,     3};
        v[1] = '{1'b0, 10'd254, 28'h7FFFFFC, 1'b0, 1'b0, R_OVF, F_OVF254, M_OVF254, 3};
        foreach (v[i]) begin
            drive_op(v[i]);
            wait_out(r, f, l, x);
            cmp_cnt++; if (r !== x.res) begin err_cnt++; $display("FAIL overflow[%0d] result: got %h want %h", i, r, x.res); end
            cmp_cnt++; if ((f & x.mask) !== (x.flags & x.mask)) begin err_cnt++; $display("FAIL overflow[%0d] flags: got %b want %b", i, f, x.flags); end
            cmp_cnt++; if (l !== x.lat) begin err_cnt++; $display("FAIL overflow[%0d] latency: got %0d want %0d", i, l, x.lat); end
            handshake();
        end
    endtask

    task automatic test_denormal();
        vec_t v[3];
        logic [31:0] r; logic [3:0] f; int l; exp_t x;
        v[0] = '{1'b0, 10'h3FE, 28'h4000000, 1'b0, 1'b0, 32'h00100000, 4'b0000, 4'hF, 6};
        v[1] = '{1'b0, 10'h3FF, 28'h4000003, 1'b0, 1'b0, 32'h00200000, 4'b0011, 4'hF, 5};
        v[2] = '{1'b0, 10'h338, 28'h4000000, 1'b0, 1'b0, 32'h00000000, 4'b0011, 4'hF, 3};
        foreach (v[i]) begin
            drive_op(v[i]);
            wait_out(r, f, l, x);
            cmp_cnt++; if (r !== x.res) begin err_cnt++; $display("FAIL denormal[%0d] result: got %h want %h", i, r, x.res); end
            cmp_cnt++; if ((f & x.mask) !== (x.flags & x.mask)) begin err_cnt++; $display("FAIL denormal[%0d] flags: got %b want %b", i, f, x.flags); end
            cmp_cnt++; if (l !== x.lat) begin err_cnt++; $display("FAIL denormal[%0d] latency: got %0d want %0d", i, l, x.lat); end
            handshake();
        end
    endtask

    task automatic test_special();
        vec_t v[3];
        logic [31:0] r; logic [3:0] f; int l; exp_t x;
        v[0] = '{1'b0, 10'd127, 28'h4000000, 1'b1, 1'b0, 32'h7FC00000, 4'b1000, 4'hF, 1};
        v[1] = '{1'b1, 10'd127, 28'h4000000, 1'b0, 1'b1, 32'hFF800000, 4'b0000, 4'hF, 1};
        v[2] = '{1'b1, 10'd50,  28'h0000000, 1'b0, 1'b0, 32'h80000000, 4'b0000, 4'hF, 1};
        foreach (v[i]) begin
            drive_op(v[i]);
            wait_out(r, f, l, x);
            cmp_cnt++; if (r !== x.res) begin err_cnt++; $display("FAIL special[%0d] result: got %h want %h", i, r, x.res); end
            cmp_cnt++; if ((f & x.mask) !== (x.flags & x.mask)) begin err_cnt++; $display("FAIL special[%0d] flags: got %b want %b", i, f, x.flags); end
            cmp_cnt++; if (l !== x.lat) begin err_cnt++; $display("FAIL special[%0d] latency: got %0d want %0d", i, l, x.lat); end
            handshake();
        end
    endtask

    task automatic test_nan_hold();
        vec_t v;
        logic [31:0] r; logic [3:0] f; int l; exp_t x;
        v = '{1'b0, 10'd0, 28'h1234567, 1'b1, 1'b0, 32'h7FC00000, 4'b1000, 4'hF, 1};
        drive_op(v);
        wait_out(r, f, l, x);
        cmp_cnt++; if (r !== x.res) begin err_cnt++; $display("FAIL nan_hold result: got %h want %h", r, x.res); end
        cmp_cnt++; if (f !== x.flags) begin err_cnt++; $display("FAIL nan_hold flags: got %b want %b", f, x.flags); end
        cmp_cnt++; if (l !== x.lat) begin err_cnt++; $display("FAIL nan_hold latency: got %0d want %0d", l, x.lat); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            cmp_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL nan_hold out_valid[%0d]: got %b want 1", c, out_valid); end
            cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL nan_hold in_ready[%0d]: got %b want 0", c, in_ready); end
            cmp_cnt++; if (result !== x.res) begin err_cnt++; $display("FAIL nan_hold stable[%0d]: got %h want %h", c, result, x.res); end
        end
        handshake();
        cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL nan_release in_ready: got %b want 1", in_ready); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL nan_release out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_align();
        in_sign  = 1'b0;
        in_exp   = 10'd130;
        in_sig   = 28'h0800000;
        in_nan   = 1'b0;
        in_inf   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL mid_align busy: in_ready got %b want 0", in_ready); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL mid_align in_ready: got %b want 1", in_ready); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_align out_valid: got %b want 0", out_valid); end
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_align discarded: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        vec_t v0, v1;
        logic [31:0] r; logic [3:0] f; int l; exp_t x;
        v0 = '{1'b0, 10'd10,  28'h0000000, 1'b0, 1'b0, 32'h00000000, 4'b0000, 4'hF, 1};
        v1 = '{1'b0, 10'd127, 28'h4000000, 1'b0, 1'b0, 32'h3F800000, 4'b0000, 4'hF, 3};
        out_ready = 1'b1;
        drive_op(v0);
        wait_out(r, f, l, x);
        cmp_cnt++; if (r !== x.res) begin err_cnt++; $display("FAIL b2b first result: got %h want %h", r, x.res); end
        cmp_cnt++; if (l !== x.lat) begin err_cnt++; $display("FAIL b2b first latency: got %0d want %0d", l, x.lat); end
        @(posedge clk);
        @(negedge clk);
        cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b idle in_ready: got %b want 1", in_ready); end
        drive_op(v1);
        wait_out(r, f, l, x);
        cmp_cnt++; if (r !== x.res) begin err_cnt++; $display("FAIL b2b second result: got %h want %h", r, x.res); end
        cmp_cnt++; if (l !== x.lat) begin err_cnt++; $display("FAIL b2b second latency: got %0d want %0d", l, x.lat); end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_normalize();
        test_rounding();
        test_overflow();
        test_denormal();
        test_special();
        test_nan_hold();
        test_reset_mid_align();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
